btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- User-input conditioning block: synchronises a raw push-button pin, debounces it, and emits clean level and single-cycle event pulses.
- Sits between the board buttons and the LED/counter logic in the 10 MHz domain.
- Drives control inputs such as pause, direction and step to the LED sequencer.

Parameters:
- CLK_FREQ_HZ, 10_000_000: frequency of clk, in Hz.
- DEBOUNCE_MS, 20: required stable time before a level change is accepted. DB_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS, which must be >= 1.
- LONG_PRESS_MS, 1000: hold time after an accepted press before btn_long fires. LONG_CYCLES = CLK_FREQ_HZ/1000*LONG_PRESS_MS, which must be >= 1.
- REPEAT_MS, 200: auto-repeat interval. REPEAT_CYCLES = CLK_FREQ_HZ/1000*REPEAT_MS. Used only with the optional feature.
- SYNC_STAGES, 2: number of synchroniser flops on btn_in, >= 2.

Ports:
- clk, input, 1: system clock (10 MHz MMCM output).
- reset, input, 1: synchronous, active-high reset.
- btn_in, input, 1: raw asynchronous button pin, active-high.
- btn_level, output, 1: debounced button state.
- btn_press, output, 1: one-cycle pulse on an accepted press, and on each auto-repeat.
- btn_release, output, 1: one-cycle pulse on an accepted release.
- btn_long, output, 1: one-cycle pulse when the hold time reaches LONG_CYCLES.

Behaviour:
- Reset:
  - Applies on a clk edge with reset=1.
  - Sync flops, all counters and all outputs go to 0; FSM goes to IDLE.
  - Reset overrides every other event in the same cycle.
- Synchroniser: a SYNC_STAGES-deep flop chain; s = last stage. No logic reads btn_in directly.
- Counter widths: each counter is $clog2(max count + 1) bits and saturates; none may wrap.
- FSM states:
  - IDLE (btn_level=0)
  - DB_PRESS (btn_level=0)
  - HELD (btn_level=1)
  - LONG_HELD (btn_level=1)
  - DB_RELEASE (btn_level=1)
- IDLE: when s=1, go to DB_PRESS and set db_cnt=1.
- DB_PRESS:
  - s=0: go back to IDLE, clear db_cnt. This is a glitch: no output changes.
  - s=1 and db_cnt reaches DB_CYCLES: go to HELD on that edge. btn_level goes to 1 and btn_press pulses for 1 cycle. Clear hold_cnt.
  - Otherwise: increment db_cnt.
- HELD:
  - hold_cnt increments each cycle.
  - When hold_cnt reaches LONG_CYCLES with s=1: pulse btn_long for 1 cycle and go to LONG_HELD.
  - s=0: go to DB_RELEASE with db_cnt=1.
- LONG_HELD: hold while s=1. On s=0, go to DB_RELEASE.
- DB_RELEASE:
  - s=1: return to HELD if the press had not gone long, or to LONG_HELD if it had (tracked with a 1-bit flag). hold_cnt is not reset, so the long-press timer continues.
  - s=0 for DB_CYCLES consecutive cycles: go to IDLE. btn_level goes to 0 and btn_release pulses for 1 cycle.
- Latency:
  - Clean edge on btn_in: btn_level changes SYNC_STAGES + DB_CYCLES clk edges later. btn_press / btn_release pulse in the same cycle btn_level changes.
  - btn_long pulses LONG_CYCLES cycles after btn_press.
- Boundary conditions:
  - Pulses are never wider than 1 cycle.
  - btn_press and btn_release are never asserted together.
  - btn_long and btn_release are never asserted together: a release accepted on the same cycle hold_cnt would hit the limit does not emit btn_long.
  - If the button is held through reset deassertion, the block must re-debounce and produce a fresh btn_press.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - In LONG_HELD, a rep_cnt counts cycles. Each time it reaches REPEAT_CYCLES, btn_press pulses for 1 cycle and rep_cnt clears.
  - rep_cnt clears on entry to LONG_HELD.
  - Repeats stop in DB_RELEASE and resume on return to LONG_HELD with rep_cnt cleared.
- Not defined: no rep_cnt logic exists; btn_press fires exactly once per accepted press; REPEAT_MS is ignored.

Test Plan:
All tests use CLK_FREQ_HZ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20, REPEAT_MS=5, SYNC_STAGES=2.
- Clean press: btn_in 0->1 at edge 0 and held for 10 cycles -> btn_level=1 and btn_press=1 at edge 6 only. No btn_long.
- Bounce: btn_in toggles 1,0,1,0 on alternate cycles, then stays 1 -> no output change during bouncing; exactly one btn_press, 6 edges after the final rise.
- Long press: held for 40 cycles, then released -> btn_press at edge 6, btn_long at edge 26, btn_release 6 edges after the fall; btn_level returns to 0 at that point.
- Release glitch: while HELD, btn_in low for 2 cycles -> btn_level stays 1, no btn_release, btn_long still at edge 26.
- Reset mid-hold: reset=1 at edge 15 for 1 cycle with btn_in still 1 -> all outputs 0 at edge 16; new btn_press at edge 22.
- With BTN_DEBOUNCE_AUTO_REPEAT_EN and a hold of 40 cycles -> extra btn_press pulses at edges 31 and 36, plus 41 if still held.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release/long-press pulses.
// Optional auto-repeat of btn_press during a long hold: define BTN_DEBOUNCE_AUTO_REPEAT_EN.
module btn_debounce #(
    parameter int CLK_FREQ_HZ   = 10_000_000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_CYCLES     = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES   = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
    localparam int REPEAT_CYCLES = CLK_FREQ_HZ / 1000 * REPEAT_MS;
    localparam int DB_W          = $clog2(DB_CYCLES + 1);
    localparam int LONG_W        = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_CYCLES);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    if (DB_CYCLES < 1)   begin : g_bad_db   $error("DB_CYCLES must be >= 1");   end
    if (LONG_CYCLES < 1) begin : g_bad_long $error("LONG_CYCLES must be >= 1"); end
    if (SYNC_STAGES < 2) begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    if (REPEAT_CYCLES < 1) begin : g_bad_rep $error("REPEAT_CYCLES must be >= 1"); end
`else
    if (REPEAT_CYCLES < 0) begin : g_bad_rep $error("REPEAT_CYCLES must be >= 0"); end
`endif

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG_HELD,
        DB_RELEASE
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     s;
    logic [DB_W-1:0]          db_cnt;
    logic [LONG_W-1:0]        hold_cnt;
    logic                     was_long;

    // NOTE: the synchroniser is cleared by reset so a button held through reset
    // is seen as a fresh rising edge and gets debounced again.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            was_long    <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state  <= DB_PRESS;
                        db_cnt <= DB_ONE;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_MAX) begin
                        state     <= HELD;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                        hold_cnt  <= '0;
                        was_long  <= 1'b0;
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                HELD: begin
                    if (hold_cnt < LONG_MAX) hold_cnt <= hold_cnt + LONG_W'(1);
                    if (!s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= DB_ONE;
                    end else if (hold_cnt >= LONG_LAST) begin
                        state    <= LONG_HELD;
                        btn_long <= 1'b1;
                        was_long <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rep_cnt  <= '0;
`endif
                    end
                end
                LONG_HELD: begin
                    if (!s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= DB_ONE;
                    end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    else if (rep_cnt >= REP_LAST) begin
                        btn_press <= 1'b1;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
`endif
                end
                DB_RELEASE: begin
                    // Long-press timer keeps running through a release glitch.
                    if (hold_cnt < LONG_MAX) hold_cnt <= hold_cnt + LONG_W'(1);
                    if (s) begin
                        state  <= was_long ? LONG_HELD : HELD;
                        db_cnt <= '0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rep_cnt <= '0;
`endif
                    end else if (db_cnt >= DB_MAX) begin
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                        db_cnt      <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: per-edge expected-output table with a scoreboard
// queue, plus hand-written sequences for reset-held and long-hold repeat counting.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level, btn_press, btn_release, btn_long;

    always #5 clk = ~clk;

    btn_debounce #(
        .CLK_FREQ_HZ  (1000),
        .DEBOUNCE_MS  (4),
        .LONG_PRESS_MS(20),
        .REPEAT_MS    (5),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    typedef struct {
        string       name;
        logic [63:0] pattern;   // btn_in value set up before edge k
        int          rst_edge;  // edge with reset=1, or -1
        int          ncyc;
        logic [63:0] level_m;
        logic [63:0] press_m;
        logic [63:0] rel_m;
        logic [63:0] long_m;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] exp;        // {level, press, release, long}
    } sb_t;

    vec_t vecs[7];
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] bit_at(int e);
        return (e >= 0 && e < 64) ? (64'd1 << e) : 64'd0;
    endfunction

    function automatic logic [63:0] span(int a, int b);
        logic [63:0] m = '0;
        for (int i = a; i < b; i++) m |= bit_at(i);
        return m;
    endfunction

    // Auto-repeat presses every 5 cycles after btn_long while LONG_HELD still sees s=1
    // (the last such edge is fall+1 with a 2-stage synchroniser).
    function automatic logic [63:0] rep_mask(int long_e, int fall);
        logic [63:0] m = '0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        for (int e = long_e + 5; e <= fall + 1; e += 5) m |= bit_at(e);
`endif
        return m;
    endfunction

    task automatic check(string what, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", what, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset  = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(vec_t v);
        sb_t e;
        reset_dut();
        for (int k = 0; k < v.ncyc; k++) begin
            btn_in = v.pattern[k];
            reset  = (k == v.rst_edge);
            sb_q.push_back('{cyc: k, exp: {v.level_m[k], v.press_m[k], v.rel_m[k], v.long_m[k]}});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("%s edge %0d {lvl,prs,rel,lng}", v.name, e.cyc),
                  {btn_level, btn_press, btn_release, btn_long}, e.exp);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n_press, n_long, n_rel, rel_edge, overlap;

        vecs[0] = '{"clean_press", span(0, 10), -1, 24,
                    span(6, 16), bit_at(6), bit_at(16), 64'd0};
        vecs[1] = '{"bounce", bit_at(0) | bit_at(2) | span(4, 20), -1, 32,
                    span(10, 26), bit_at(10), bit_at(26), 64'd0};
        vecs[2] = '{"long_press", span(0, 40), -1, 52,
                    span(6, 46), bit_at(6) | rep_mask(26, 40), bit_at(46), bit_at(26)};
        vecs[3] = '{"release_glitch", span(0, 10) | span(12, 40), -1, 52,
                    span(6, 46), bit_at(6) | rep_mask(26, 40), bit_at(46), bit_at(26)};
        vecs[4] = '{"reset_mid_hold", span(0, 31), 15, 44,
                    span(6, 15) | span(22, 37), bit_at(6) | bit_at(22), bit_at(37), 64'd0};
        vecs[5] = '{"release_at_long_limit", span(0, 24), -1, 36,
                    span(6, 30), bit_at(6), bit_at(30), 64'd0};
        vecs[6] = '{"reset_on_press_edge", span(0, 20), 6, 32,
                    span(13, 26), bit_at(13), bit_at(26), 64'd0};

        reset  = 1'b1;
        btn_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state {lvl,prs,rel,lng}",
              {btn_level, btn_press, btn_release, btn_long}, 4'b0000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Button held through reset: a fresh press must appear 6 edges after release of reset.
        @(negedge clk);
        reset  = 1'b1;
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt   = 0;
        while (cnt < 20) begin
            @(posedge clk);
            #1;
            if (btn_press) break;
            cnt++;
        end
        check("held_through_reset press edge", 4'(cnt), 4'd6);

        // Long hold of 60 cycles: count pulses over a bounded window.
        reset_dut();
        n_press  = 0;
        n_long   = 0;
        n_rel    = 0;
        rel_edge = -1;
        overlap  = 0;
        for (int k = 0; k < 80; k++) begin
            btn_in = (k < 60);
            @(posedge clk);
            #1;
            if (btn_press) n_press++;
            if (btn_long) n_long++;
            if (btn_release) begin
                n_rel++;
                rel_edge = k;
            end
            if ((btn_press && btn_release) || (btn_long && btn_release)) overlap++;
            @(negedge clk);
        end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        check("long_hold press count", 4'(n_press), 4'd8);
`else
        check("long_hold press count", 4'(n_press), 4'd1);
`endif
        check("long_hold long count", 4'(n_long), 4'd1);
        check("long_hold release count", 4'(n_rel), 4'd1);
        check("long_hold release edge", 4'(rel_edge - 60), 4'd6);
        check("long_hold pulse overlap", 4'(overlap), 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
